// File: rtl/pool_pkg.sv
// Shared types, constants and packing helper for the pool_sched_8_4 sequencer.
package pool_pkg;

  localparam int PIX_W  = 9;
  localparam int OUT_W  = 4;
  localparam int WIN    = 4;
  localparam int POOL_W = PIX_W * WIN;
  localparam int K_W    = 3;

  localparam logic [3:0] WDOG_LIMIT = 4'd15;

  // Window slots in the packed word, most significant first: TL, TR, BL, BR.
  localparam int SLOT_TL_HI = 35;
  localparam int SLOT_TL_LO = 27;
  localparam int SLOT_TR_HI = 26;
  localparam int SLOT_TR_LO = 18;
  localparam int SLOT_BL_HI = 17;
  localparam int SLOT_BL_LO = 9;
  localparam int SLOT_BR_HI = 8;
  localparam int SLOT_BR_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic [POOL_W-1:0] put_slot(input logic [POOL_W-1:0] word,
                                                 input logic [1:0]        slot,
                                                 input logic [PIX_W-1:0]  pix);
    logic [POOL_W-1:0] res;
    res = word;
    case (slot)
      2'd0:    res[SLOT_TL_HI:SLOT_TL_LO] = pix;
      2'd1:    res[SLOT_TR_HI:SLOT_TR_LO] = pix;
      2'd2:    res[SLOT_BL_HI:SLOT_BL_LO] = pix;
      2'd3:    res[SLOT_BR_HI:SLOT_BR_LO] = pix;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pool_sched_8_4_if.sv
// Bus bundle between the layer top, the feature/output RAMs, the pool unit and the sequencer.
// timeout_err exists only when POOL_SCHED_TIMEOUT_EN is defined.
interface pool_sched_8_4_if #(
  parameter int RD_AW = 6,
  parameter int WR_AW = 4
);
  import pool_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [RD_AW-1:0]   rd_addr;
  logic [PIX_W-1:0]   rd_data;
  logic [POOL_W-1:0]  pool_in;
  logic               pool_start;
  logic [OUT_W-1:0]   pool_out;
  logic               pool_end;
  logic               wr_en;
  logic [WR_AW-1:0]   wr_addr;
  logic [OUT_W-1:0]   wr_data;
`ifdef POOL_SCHED_TIMEOUT_EN
  logic               timeout_err;
`endif

  modport master (
    input  start, rd_data, pool_out, pool_end,
    output busy, done, rd_en, rd_addr, pool_in, pool_start, wr_en, wr_addr, wr_data
`ifdef POOL_SCHED_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport slave (
    output start, rd_data, pool_out, pool_end,
    input  busy, done, rd_en, rd_addr, pool_in, pool_start, wr_en, wr_addr, wr_data
`ifdef POOL_SCHED_TIMEOUT_EN
    , input timeout_err
`endif
  );

endinterface

// File: rtl/pool_win_addr.sv
// Window/offset address generator: walks 2x2 windows row-major and the four pixels of each.
// Addresses are registered from the next counter values so they line up with the FSM strobes.
module pool_win_addr
  import pool_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int RD_AW  = 6,
  parameter int WR_AW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             k_inc,
  input  logic             win_adv,
  output logic [K_W-1:0]   k,
  output logic [RD_AW-1:0] rd_addr,
  output logic [WR_AW-1:0] wr_addr,
  output logic             last_win,
  output logic             wrap
);

  localparam int WX_N = WIDTH / 32'sd2;
  localparam int WY_N = HEIGHT / 32'sd2;
  localparam int WX_W = (WX_N > 32'sd1) ? $clog2(WX_N) : 32'sd1;
  localparam int WY_W = (WY_N > 32'sd1) ? $clog2(WY_N) : 32'sd1;

  logic [WX_W-1:0]  wx_q, wx_d;
  logic [WY_W-1:0]  wy_q, wy_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [RD_AW-1:0] rd_addr_q, rd_addr_d;
  logic [WR_AW-1:0] wr_addr_q, wr_addr_d;

  assign wrap     = (int'(wx_q) == WX_N - 32'sd1);
  assign last_win = wrap && (int'(wy_q) == WY_N - 32'sd1);

  // Counter advance; {wy,dy} and {wx,dx} give 2*wy+dy and 2*wx+dx directly.
  always_comb begin
    wx_d = wx_q;
    wy_d = wy_q;
    k_d  = k_q;
    if (clear) begin
      wx_d = '0;
      wy_d = '0;
      k_d  = '0;
    end else if (win_adv) begin
      k_d = '0;
      if (last_win) begin
        wx_d = '0;
        wy_d = '0;
      end else if (wrap) begin
        wx_d = '0;
        wy_d = wy_q + WY_W'(1'b1);
      end else begin
        wx_d = wx_q + WX_W'(1'b1);
      end
    end else if (k_inc) begin
      k_d = k_q + 3'd1;
    end else begin
      k_d = k_q;
    end
    rd_addr_d = RD_AW'(int'({wy_d, k_d[1]}) * WIDTH + int'({wx_d, k_d[0]}));
    wr_addr_d = WR_AW'(int'(wy_d) * WX_N + int'(wx_d));
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wx_q      <= '0;
      wy_q      <= '0;
      k_q       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      k_q       <= k_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign k       = k_q;
  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: rtl/pool_sched_8_4.sv
// Sequencer driving the 2x2 max-pool/clamp unit over a WIDTH x HEIGHT feature map.
// Define POOL_SCHED_TIMEOUT_EN to add the WAIT watchdog and bus.timeout_err.
module pool_sched_8_4
  import pool_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int RD_AW  = 6,
  parameter int WR_AW  = 4
) (
  input  logic              clk,
  input  logic              reset,
  pool_sched_8_4_if.master  bus
);

  state_e             state_q, state_d;
  logic [POOL_W-1:0]  pool_in_q, pool_in_d;
  logic [OUT_W-1:0]   wr_data_q, wr_data_d;
  logic               rd_en_q, rd_en_d;
  logic               pool_start_q, pool_start_d;
  logic               wr_en_q, wr_en_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               clear_s, k_inc_s, win_adv_s, last_win_s, wrap_s;
  logic [K_W-1:0]     k_s;
  logic [1:0]         slot_s;
  logic [RD_AW-1:0]   rd_addr_s;
  logic [WR_AW-1:0]   wr_addr_s;

`ifdef POOL_SCHED_TIMEOUT_EN
  logic [3:0]         wdog_q, wdog_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  pool_win_addr #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .RD_AW  (RD_AW),
    .WR_AW  (WR_AW)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .k_inc    (k_inc_s),
    .win_adv  (win_adv_s),
    .k        (k_s),
    .rd_addr  (rd_addr_s),
    .wr_addr  (wr_addr_s),
    .last_win (last_win_s),
    .wrap     (wrap_s)
  );

  // Read data returns one cycle after its strobe, so fetch step k fills slot k-1.
  assign slot_s = 2'(k_s - 3'd1);

  // Next-state logic; strobes are registered from the next state.
  always_comb begin
    state_d   = state_q;
    clear_s   = 1'b0;
    k_inc_s   = 1'b0;
    win_adv_s = 1'b0;
    pool_in_d = pool_in_q;
    wr_data_d = wr_data_q;
`ifdef POOL_SCHED_TIMEOUT_EN
    wdog_d        = 4'd0;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          clear_s = 1'b1;
`ifdef POOL_SCHED_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (k_s != 3'd0) begin
          pool_in_d = put_slot(pool_in_q, slot_s, bus.rd_data);
        end else begin
          pool_in_d = pool_in_q;
        end
        if (k_s == 3'd4) begin
          state_d = ST_ISSUE;
        end else begin
          k_inc_s = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.pool_end) begin
          wr_data_d = bus.pool_out;
          state_d   = ST_WRITE;
        end
`ifdef POOL_SCHED_TIMEOUT_EN
        else if (wdog_q == WDOG_LIMIT - 4'd1) begin
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          wdog_d = wdog_q + 4'd1;
        end
`else
        else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_WRITE: begin
        win_adv_s = 1'b1;
        if (wrap_s && last_win_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rd_en_d      = (state_d == ST_FETCH) && ((state_q != ST_FETCH) || (k_s < 3'd3));
    pool_start_d = (state_d == ST_ISSUE);
    wr_en_d      = (state_d == ST_WRITE);
    done_d       = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pool_in_q    <= '0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      pool_start_q <= 1'b0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef POOL_SCHED_TIMEOUT_EN
      wdog_q        <= 4'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pool_in_q    <= pool_in_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      pool_start_q <= pool_start_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
`ifdef POOL_SCHED_TIMEOUT_EN
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_s;
  assign bus.pool_in    = pool_in_q;
  assign bus.pool_start = pool_start_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_s;
  assign bus.wr_data    = wr_data_q;
`ifdef POOL_SCHED_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_pool_sched_8_4.sv
// Scoreboard bench for pool_sched_8_4: feature maps are modelled as arrays, expected
// windows/results are pushed per pass and a negedge monitor pops them on each strobe.
module tb_pool_sched_8_4;
  import pool_pkg::*;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NWX  = W / 2;
  localparam int NWIN = (W / 2) * (H / 2);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic signed [PIX_W-1:0] mem [W*H];
  logic [7:0]        exp_wr  [$];
  logic [POOL_W-1:0] exp_pin [$];

  int   wr_cnt = 0, done_cnt = 0, pstart_cnt = 0, done_cyc = 0, first_rd_cyc = -1;
  logic [POOL_W-1:0] first_pin = '0;
  logic done_terr = 1'b0;
  int   lat  = 4;
  bit   hang = 1'b0;
  int   pool_cnt = 0;
  logic [OUT_W-1:0] pool_res = '0;
  logic [7:0] mon_e;
  int   mon_ns;

  pool_sched_8_4_if #(.RD_AW(6), .WR_AW(4)) bus ();

  pool_sched_8_4 #(.WIDTH(W), .HEIGHT(H), .RD_AW(6), .WR_AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Window rule: max of four signed pixels, clamped to 0..15.
  function automatic int clamp_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 0) m = 0;
    if (m > 15) m = 15;
    return m;
  endfunction

  function automatic logic [OUT_W-1:0] pool_unit(input logic [POOL_W-1:0] pin);
    return 4'(clamp_max(int'($signed(pin[35:27])), int'($signed(pin[26:18])),
                        int'($signed(pin[17:9])),  int'($signed(pin[8:0]))));
  endfunction

  // Feature RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  // Pool unit: pool_end in the lat-th cycle after the start pulse.
  always @(posedge clk) begin
    if (reset) begin
      pool_cnt <= 0;
      pool_res <= '0;
    end else if (bus.pool_start) begin
      pool_cnt <= 1;
      pool_res <= pool_unit(bus.pool_in);
    end else if (pool_cnt != 0 && pool_cnt < lat) begin
      pool_cnt <= pool_cnt + 1;
    end else begin
      pool_cnt <= 0;
    end
  end
  assign bus.pool_end = (pool_cnt == lat) && !hang;
  assign bus.pool_out = pool_res;

  task automatic push_pass();
    for (int w = 0; w < NWIN; w++) begin
      int b;
      b = (w / NWX) * 2 * W + (w % NWX) * 2;
      exp_pin.push_back({mem[b], mem[b+1], mem[b+W], mem[b+W+1]});
      exp_wr.push_back({4'(w), 4'(clamp_max(int'(mem[b]), int'(mem[b+1]),
                                             int'(mem[b+W]), int'(mem[b+W+1])))});
    end
  endtask

  // Monitor: pops expectations on every strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_en) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d, none expected", bus.wr_addr, bus.wr_data);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", bus.wr_addr, mon_e[7:4]);
          chk("wr_data", bus.wr_data, mon_e[3:0]);
        end
      end
      if (bus.pool_start) begin
        pstart_cnt++;
        if (pstart_cnt == 1) first_pin = bus.pool_in;
        if (exp_pin.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pool_start: pool_in %0h", bus.pool_in);
        end else begin
          chk("pool_in", bus.pool_in, exp_pin.pop_front());
        end
      end
      if (bus.rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", bus.busy, 1'b1);
`ifdef POOL_SCHED_TIMEOUT_EN
        done_terr = bus.timeout_err;
`endif
      end
      mon_ns = int'(bus.rd_en) + int'(bus.pool_start) + int'(bus.wr_en) + int'(bus.done);
      if (mon_ns != 0) chk("strobe_exclusive", mon_ns, 1);
    end
  end

  task automatic run_pass(input int ghost_at, input bit timed);
    int s, to;
    push_pass();
    wr_cnt = 0; done_cnt = 0; pstart_cnt = 0; first_rd_cyc = -1;
    @(posedge clk); #1; bus.start = 1'b1; s = cyc;
    @(posedge clk); #1; bus.start = 1'b0;
`ifdef POOL_SCHED_TIMEOUT_EN
    chk("timeout_clr", bus.timeout_err, 1'b0);
`endif
    to = 0;
    while (done_cnt == 0 && to < 3000) begin
      @(posedge clk); #1; to++;
      bus.start = (ghost_at > 0) && (cyc == s + ghost_at);
    end
    bus.start = 1'b0;
    chk("done_seen", done_cnt, 1);
    if (timed) begin
      chk("first_rd_cycle", first_rd_cyc - s, 1);
      chk("done_cycle", done_cyc - s, 177);
    end
    @(negedge clk);
    chk("busy_after_done", bus.busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("write_count", wr_cnt, NWIN);
    chk("done_count", done_cnt, 1);
    chk("scoreboard_empty", exp_wr.size(), 0);
  endtask

  initial begin
    int s, to;
    bus.start = 1'b0;
    bus.rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.pool_in, bus.pool_start,
                          bus.wr_en, bus.wr_addr, bus.wr_data}, 64'd0);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_outputs", {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.pool_in, bus.pool_start,
                           bus.wr_en, bus.wr_addr, bus.wr_data}, 64'd0);
    end

    for (int i = 0; i < W*H; i++) mem[i] = 9'(i - 32);
    run_pass(0, 1'b1);
    chk("win0_pool_in", first_pin, {9'h1E0, 9'h1E1, 9'h1E8, 9'h1E9});

    for (int i = 0; i < W*H; i++) mem[i] = 9'h1FF;
    mem[9] = 9'd5;
    run_pass(0, 1'b1);
    chk("slot_br", first_pin[8:0], 9'd5);
    chk("slots_other", first_pin[35:9], {27{1'b1}});

    for (int i = 0; i < W*H; i++) mem[i] = 9'(int'($urandom_range(0, 47)) - 24);
    run_pass(50, 1'b1);

    // Abort during the WAIT of window 7.
    for (int i = 0; i < W*H; i++) mem[i] = 9'(int'($urandom_range(0, 47)) - 24);
    push_pass();
    wr_cnt = 0; done_cnt = 0; pstart_cnt = 0;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    to = 0;
    while (pstart_cnt < 8 && to < 500) begin
      @(posedge clk); #1; to++;
    end
    chk("reached_win7", pstart_cnt, 8);
    reset = 1'b1;
    exp_wr.delete();
    exp_pin.delete();
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_write_count", wr_cnt, 7);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_no_done", done_cnt, 0);
    run_pass(0, 1'b1);

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < W*H; i++) mem[i] = 9'(int'($urandom_range(0, 47)) - 24);
      lat = int'($urandom_range(1, 8));
      run_pass(0, 1'b0);
    end
    lat = 4;

`ifdef POOL_SCHED_TIMEOUT_EN
    hang = 1'b1;
    exp_pin.push_back({mem[0], mem[1], mem[W], mem[W+1]});
    wr_cnt = 0; done_cnt = 0; pstart_cnt = 0;
    @(posedge clk); #1; bus.start = 1'b1; s = cyc;
    @(posedge clk); #1; bus.start = 1'b0;
    to = 0;
    while (done_cnt == 0 && to < 200) begin
      @(posedge clk); #1; to++;
    end
    chk("to_done_seen", done_cnt, 1);
    chk("to_done_cycle", done_cyc - s, 22);
    chk("to_err_at_done", done_terr, 1'b1);
    repeat (10) @(negedge clk);
    chk("to_write_count", wr_cnt, 0);
    chk("to_done_count", done_cnt, 1);
    chk("to_err_held", bus.timeout_err, 1'b1);
    hang = 1'b0;
    run_pass(0, 1'b1);
`else
    s = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, checks %0d", checks);
    $fatal(1, "global timeout");
  end

endmodule
